// File: rtl/div_unit_seq.sv
// div_unit_seq: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit is resolved per cycle with a shift and a trial subtract;
// the borrow of the trial difference decides between keeping the difference
// and restoring the shifted remainder.
// Build option: define DIV_SIGNED_EN to support the signed encodings
// (DIV/REM). Without it funct_i[0] is ignored and all ops run unsigned.
module div_unit_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      funct_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] rd_o
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    logic              is_rem;
    logic [XLEN-1:0]   dividend;
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   rem;
    logic [CNT_W-1:0]  count;

    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   zero_result;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quot_next;
    logic [XLEN-1:0]   final_result;

`ifdef DIV_SIGNED_EN
    logic              q_neg;
    logic              r_neg;
    logic              op_signed;
    logic              sign_a;
    logic              sign_b;

    // Conditional two's-complement negation: (x ^ {s}) + s.
    // 0x8000_0000 maps to itself and is then treated as unsigned 2^31.
    function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] x,
                                                  input logic            s);
        return (x ^ {XLEN{s}}) + {{(XLEN-1){1'b0}}, s};
    endfunction

    // Operand magnitudes and result signs for the signed encodings
    always_comb begin
        op_signed = ~funct_i[0];
        sign_a    = op_signed & rs1_i[XLEN-1];
        sign_b    = op_signed & rs2_i[XLEN-1];
        op_a      = negate_if(rs1_i, sign_a);
        op_b      = negate_if(rs2_i, sign_b);
    end
`else
    logic              unused_funct0;

    assign unused_funct0 = funct_i[0];

    // Unsigned-only build: operands are used exactly as given
    always_comb begin
        op_a = rs1_i;
        op_b = rs2_i;
    end
`endif

    // Divide-by-zero result: all ones for a quotient, dividend for a remainder
    always_comb begin
        zero_result = funct_i[1] ? rs1_i : {XLEN{1'b1}};
    end

    // One restoring step: trial subtract, then keep or restore on the borrow
    always_comb begin
        trial     = {rem, dividend[XLEN-1]} - {1'b0, divisor};
        rem_next  = trial[XLEN] ? {rem[XLEN-2:0], dividend[XLEN-1]}
                                : trial[XLEN-1:0];
        quot_next = {dividend[XLEN-2:0], ~trial[XLEN]};
    end

    // Result selection and sign fix-up applied on the last iteration
    always_comb begin
`ifdef DIV_SIGNED_EN
        final_result = is_rem ? negate_if(rem_next, r_neg)
                              : negate_if(quot_next, q_neg);
`else
        final_result = is_rem ? rem_next : quot_next;
`endif
    end

    // Control FSM and datapath registers; quotient bits shift into the
    // dividend register as dividend bits are consumed from its top
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            rd_o     <= '0;
            is_rem   <= 1'b0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            count    <= '0;
`ifdef DIV_SIGNED_EN
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        is_rem   <= funct_i[1];
                        dividend <= op_a;
                        divisor  <= op_b;
                        rem      <= '0;
                        count    <= CNT_W'(XLEN - 1);
                        busy_o   <= 1'b1;
`ifdef DIV_SIGNED_EN
                        q_neg    <= sign_a ^ sign_b;
                        r_neg    <= sign_a;
`endif
                        if (rs2_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            rd_o   <= zero_result;
                        end else begin
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    dividend <= quot_next;
                    rem      <= rem_next;
                    count    <= count - CNT_W'(1);
                    if (count == '0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        rd_o   <= final_result;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit_seq.sv
// tb_div_unit_seq: scoreboard bench for div_unit_seq.
// Expected results come from a behavioural divide model and are queued when
// an operation is started; a monitor pops and compares them on done_o,
// including the cycle on which done_o must appear.
// Honours DIV_SIGNED_EN the same way the design does.
module tb_div_unit_seq;

`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  funct_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rd_o;

    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    logic [31:0] last_rd  = '0;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        int          due;
    } exp_t;

    exp_t sb[$];

    div_unit_seq #(.XLEN(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .funct_i (funct_i),
        .rs1_i   (rs1_i),
        .rs2_i   (rs2_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .rd_o    (rd_o)
    );

    // Free-running clock, 10 time units per period
    always #5 clk_i = ~clk_i;

    // Cycle counter used to time done_o against the start edge
    always @(posedge clk_i) cycle <= cycle + 1;

    // Count one comparison and report it when observed and expected differ
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural reference for all four RV32M divide encodings
    function automatic logic [31:0] model(input logic [1:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic        sgn;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        sgn = SIGNED_EN && !f[0];
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
        return f[1] ? r : q;
    endfunction

    // Monitor: every done_o pulse must match the oldest queued expectation
    always @(negedge clk_i) begin
        exp_t e;
        if (done_o) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.tag, "_rd"}, rd_o, e.rd);
                checkOutput({e.tag, "_lat"}, 32'(cycle), 32'(e.due));
                last_rd = e.rd;
            end
        end
    end

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Start one operation, queue its expected result and due cycle
    task automatic applyStimulus(input string tag, input logic [1:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start_i = 1'b1;
        funct_i = f;
        rs1_i   = a;
        rs2_i   = b;
        e.tag   = tag;
        e.rd    = model(f, a, b);
        e.due   = cycle + ((b == 32'd0) ? 1 : 33);
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        checkOutput({tag, "_busy"}, 32'(busy_o), 32'd1);
    endtask

    // Wait, with a cycle budget, for all queued results to be delivered
    task automatic waitIdle();
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Main stimulus sequence
    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        funct_i = 2'b00;
        rs1_i   = '0;
        rs2_i   = '0;
        idleCycles(2);
        rst_i = 1'b0;
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        checkOutput("reset_done", 32'(done_o), 32'd0);
        checkOutput("reset_rd",   rd_o,        32'd0);

        applyStimulus("divu_100_7", 2'b01, 32'd100, 32'd7);          waitIdle();
        applyStimulus("remu_100_7", 2'b11, 32'd100, 32'd7);          waitIdle();
        applyStimulus("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2);    waitIdle();
        applyStimulus("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2);    waitIdle();
        applyStimulus("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF); waitIdle();
        applyStimulus("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF); waitIdle();
        applyStimulus("divu_5_0",   2'b01, 32'd5, 32'd0);            waitIdle();
        applyStimulus("rem_m5_0",   2'b10, 32'hFFFF_FFFB, 32'd0);    waitIdle();
        applyStimulus("div_m1_2",   2'b00, 32'hFFFF_FFFF, 32'd2);    waitIdle();
        applyStimulus("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);    waitIdle();
        applyStimulus("remu_3_10",  2'b11, 32'd3, 32'd10);           waitIdle();

        // A start pulse during CALC must be ignored and not queued
        applyStimulus("divu_ign", 2'b01, 32'd1000, 32'd3);
        idleCycles(9);
        start_i = 1'b1;
        funct_i = 2'b00;
        rs1_i   = 32'd55;
        rs2_i   = 32'd5;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        checkOutput("ign_busy",    32'(busy_o), 32'd1);
        checkOutput("ign_rd_hold", rd_o,        last_rd);
        waitIdle();
        idleCycles(40);

        // Reset in the middle of CALC aborts with no done_o
        start_i = 1'b1;
        funct_i = 2'b01;
        rs1_i   = 32'd12345;
        rs2_i   = 32'd7;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        idleCycles(5);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        checkOutput("abort_busy", 32'(busy_o), 32'd0);
        checkOutput("abort_done", 32'(done_o), 32'd0);
        checkOutput("abort_rd",   rd_o,        32'd0);
        idleCycles(40);

        applyStimulus("divu_after_abort", 2'b01, 32'd12345, 32'd7);  waitIdle();

        // A few random operations, including one divide by zero
        for (int i = 0; i < 6; i++) begin
            logic [1:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            f = 2'($urandom_range(0, 3));
            a = $urandom;
            if (i == 2)          b = 32'd0;
            else if (i % 2 == 1) b = 32'($urandom_range(1, 100));
            else                 b = $urandom;
            applyStimulus($sformatf("rnd%0d", i), f, a, b);
            waitIdle();
        end

        idleCycles(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
